// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encodings and payload types for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] code;
  } fetch_entry_t;

  // Word-align an address by clearing the byte offset.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush; head is shown combinationally from storage.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; flush discards everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited memory requests, response
// buffering and redirect handling with dropping of stale in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] code,
  output logic [31:0] pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] last_pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    fifo_head, fifo_push_data;
  logic [CW-1:0]   pcq_count;
  logic            pcq_empty, pcq_full;
  logic [XLEN-1:0] pcq_head;

  logic [SW-1:0]   inflight;
  logic            credit_ok;
  logic            req_fire;
  logic            rsp_live;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            dec_fire;

  // Credit covers both in-flight and buffered words so a response always has room.
  assign inflight       = SW'(outstanding_q) + SW'(fifo_count);
  assign credit_ok      = (inflight < SW'(DEPTH));
  assign imem_req_valid = (state_q != BOOT) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (drop_cnt_q == '0);
  assign rsp_keep = rsp_live && !redirect_valid;
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);

  assign dec_valid = !fifo_empty;
  assign dec_fire  = dec_valid && dec_ready;
  assign code      = fifo_empty ? NOP : fifo_head.code;
  assign pc        = fifo_empty ? last_pc_q : fifo_head.pc;

  assign fifo_push_data.pc   = pcq_head;
  assign fifo_push_data.code = imem_rsp_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // Next state: DRAIN while stale responses are still expected.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:       state_d = RUN;
      RUN, DRAIN: state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
      default:    state_d = BOOT;
    endcase
  end

  // Datapath next values; a redirect overrides normal PC advance and drop accounting.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      drop_cnt_d = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      last_pc_q     <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      if (!fifo_empty) last_pc_q <= fifo_head.pc;
    end
  end

  // Decoded-instruction buffer holding {pc, code}.
  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (fifo_push_data),
    .pop       (dec_fire),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // PCs of live requests, matched to responses in order.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_live),
    .head      (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  // Structural invariants of the credit and drop accounting.
  a_fifo_room: assert property (@(posedge clk) disable iff (!rst_n) rsp_keep |-> !fifo_full);
  a_pcq_live:  assert property (@(posedge clk) disable iff (!rst_n) rsp_keep |-> !pcq_empty);
  a_pcq_room:  assert property (@(posedge clk) disable iff (!rst_n) req_fire |-> !pcq_full);
  a_out_max:   assert property (@(posedge clk) disable iff (!rst_n) outstanding_q <= CW'(DEPTH));
  a_credit:    assert property (@(posedge clk) disable iff (!rst_n) inflight <= SW'(DEPTH));
  a_drop_le:   assert property (@(posedge clk) disable iff (!rst_n) drop_cnt_q <= outstanding_q);
  a_pcq_track: assert property (@(posedge clk) disable iff (!rst_n)
                                (pcq_count + drop_cnt_q) == outstanding_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an in-order memory model feeds responses, and each
// accepted request queues its expected {pc, code} for comparison at decode handshake.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] code;
  logic [31:0] pc;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] code; } exp_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  int          errors, checks, cyc, last_due, stale, lat_lo, lat_hi, first_dv, deliv;
  logic [31:0] exp_addr, first_req_addr, redir_pc_seen, hold_pc, hold_code;
  bit          redir_prev, arm_redir, arm_req;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .code           (code),
    .pc             (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, sample settled outputs, update the model.
  task automatic step(input bit rdy, input bit drdy, input bit redir, input logic [31:0] tgt);
    int   lat;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    imem_req_ready = rdy;
    dec_ready      = drdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend_q[0].addr);
      void'(pend_q.pop_front());
      if (stale > 0) stale--;
    end
    #1;
    if (redir_prev) check("dv_after_redir", 32'(dec_valid), 32'd0);
    if (redir)      check("no_req_on_redir", 32'(imem_req_valid), 32'd0);
    if (!dec_valid) check("nop_when_empty", code, NOP);
    if (first_dv < 0 && dec_valid) first_dv = cyc;
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_addr);
      check("credit", 32'(exp_q.size() + stale < int'(DEPTH)), 32'd1);
      if (arm_req) begin
        first_req_addr = imem_req_addr;
        arm_req = 1'b0;
      end
      lat = int'($urandom_range(lat_hi, lat_lo));
      last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      pend_q.push_back('{addr: exp_addr, due: last_due});
      exp_q.push_back('{pc: exp_addr, code: word_of(exp_addr)});
      exp_addr = exp_addr + 32'd4;
    end
    if (dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        check("dec_spurious", 32'(dec_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dec_pc", pc, e.pc);
        check("dec_code", code, e.code);
        deliv++;
        if (arm_redir) begin
          redir_pc_seen = pc;
          arm_redir = 1'b0;
        end
      end
    end
    if (redir) begin
      exp_q.delete();
      exp_addr      = {tgt[31:2], 2'b00};
      stale         = pend_q.size();
      arm_redir     = 1'b1;
      redir_pc_seen = 32'hDEAD_BEEF;
    end
    redir_prev = redir;
  endtask

  task automatic clear_model();
    pend_q.delete();
    exp_q.delete();
    cyc = 0; last_due = 0; stale = 0; first_dv = -1;
    exp_addr = RST_PC; redir_prev = 1'b0; arm_redir = 1'b0;
  endtask

  // Run until exactly two requests are pending with none due next cycle.
  task automatic wait_two_pending();
    int n;
    n = 0;
    while (!(pend_q.size() == 2 && pend_q[0].due > cyc + 1) && n < 50) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    check("two_pending", 32'(pend_q.size()), 32'd2);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_code", code, NOP);
    check("rst_pc", pc, RST_PC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    errors = 0; checks = 0; deliv = 0; arm_req = 1'b0;
    lat_lo = 1; lat_hi = 1;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    clear_model();
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming with single-cycle memory: first instruction 3 cycles after release.
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_dv_latency", 32'(first_dv), 32'd3);
    check("stream_progress", 32'(deliv >= 5), 32'd1);

    // Decode stall: buffer fills to DEPTH, requests stop, head holds steady.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      if (i == 2) begin hold_pc = pc; hold_code = code; end
    end
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_dec_valid", 32'(dec_valid), 32'd1);
    check("stall_buffered", 32'(exp_q.size()), DEPTH);
    check("stall_pc_hold", pc, hold_pc);
    check("stall_code_hold", code, hold_code);
    d0 = deliv;
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_resume", 32'(deliv > d0 + 2), 32'd1);

    // Redirect with two requests in flight: both stale words must be dropped.
    lat_lo = 3; lat_hi = 3;
    wait_two_pending();
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_first_pc", redir_pc_seen, 32'h0000_0100);

    // Redirect coinciding with the only outstanding response.
    lat_lo = 1; lat_hi = 1;
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("one_outstanding", 32'(pend_q.size()), 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    check("rsp_in_redir_cycle", 32'(imem_rsp_valid), 32'd1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_same_cycle_pc", redir_pc_seen, 32'h0000_0200);

    // Back-to-back redirects: the last target wins, byte offset ignored.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0503);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("b2b_redir_pc", redir_pc_seen, 32'h0000_0500);

    // Address wrap at the top of the 32-bit space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF6);
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_first_pc", redir_pc_seen, 32'hFFFF_FFF4);

    // Random ready, latency 1..3, decode back-pressure and occasional redirects.
    lat_lo = 1; lat_hi = 3;
    d0 = deliv;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), $urandom & 32'h0000_FFFF);
    end
    check("random_progress", 32'(deliv > d0 + 50), 32'd1);

    // Reset asserted mid-stream with two requests outstanding.
    lat_lo = 3; lat_hi = 3;
    wait_two_pending();
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    arm_req = 1'b1;
    first_req_addr = 32'hDEAD_BEEF;
    lat_lo = 1; lat_hi = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("restart_addr", first_req_addr, RST_PC);
    check("restart_dv_latency", 32'(first_dv), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode.
- Holds the PC and issues in-order requests to instruction memory over a valid/ready request channel with a fixed-order response channel.
- Buffers returned words with their PCs in a small FIFO and presents one instruction per cycle to decode.
- Accepts redirects for jumps and taken branches, then flushes and drops stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, FIFO entries and also the maximum outstanding plus buffered instructions; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req_valid  out  1  request is valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word is valid this cycle; responses return in request order, at least 1 cycle after acceptance, and are never back-pressured.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  control-flow change (JAL/JALR/taken branch).
- redirect_pc  in  32  redirect target.
- dec_valid  out  1  code/pc hold a valid instruction.
- dec_ready  in  1  decode consumes the instruction this cycle.
- code  out  32  instruction to decode.
- pc  out  32  PC of code.

Behaviour:
Reset (rst_n=0, takes effect immediately):
- fetch_pc=RESET_PC; outstanding=0; drop_cnt=0; FIFO empty; state=BOOT.
- Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, code=32'h0000_0013 (NOP), pc=RESET_PC.

States:
- BOOT: one cycle with no request, then RUN.
- RUN: normal fetching.
- DRAIN: entered when drop_cnt>0 after a redirect; returns to RUN when drop_cnt reaches 0.

Request issue:
- imem_req_valid=1 when state is RUN or DRAIN, redirect_valid=0, and outstanding + fifo_count < DEPTH.
- imem_req_addr=fetch_pc.
- On handshake (valid & ready): fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and outstanding++.
- The PC of each accepted request is pushed into an internal pc queue of DEPTH entries.

Response:
- imem_rsp_valid with drop_cnt=0: push {pc_queue head, imem_rsp_data} into the FIFO, pop the pc queue, outstanding--.
- imem_rsp_valid with drop_cnt>0: discard the word, drop_cnt--, outstanding--.
- The credit rule guarantees the FIFO is never full when a response arrives. A response arriving while the FIFO is full is an assertion error.

Decode output:
- dec_valid = FIFO non-empty; code and pc show the FIFO head.
- When the FIFO is empty, code=NOP and pc holds its last value.
- dec_valid & dec_ready pops the head.
- Push and pop in the same cycle keep the count unchanged. A push into an empty FIFO is visible the next cycle (no bypass), so minimum latency from request acceptance to dec_valid is 2 cycles.

Redirect (highest priority):
- Same cycle: no request is issued.
- Next edge: fetch_pc=redirect_pc; FIFO and pc queue cleared; drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0); outstanding keeps counting down the in-flight responses.
- A response arriving in the redirect cycle is discarded.
- The next cycle dec_valid=0. Fetch from redirect_pc may start that cycle, since credit counts all outstanding.
- A redirect during DRAIN adds to the existing drop accounting; drop_cnt always equals the stale in-flight count.
- Back-to-back redirects: the last target wins.
- redirect_pc[1:0] is ignored (forced to 0).

Invariants:
- outstanding ≤ DEPTH.
- fifo_count + outstanding ≤ DEPTH.
- drop_cnt ≤ outstanding.

Decomposition:
- Shared package/header: NOP constant 32'h0000_0013, RESET_PC default, and state encodings BOOT/RUN/DRAIN (2-bit), defined alongside the existing param_*.vh headers.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/count/empty/full and a flush input.
- fetch_fifo is instantiated twice: once 64 bits wide for {pc, code}, once 32 bits wide as the pc queue.

Test Plan:
- Reset then stream with imem_req_ready=1, 1-cycle response latency, dec_ready=1 -> addresses 0,4,8,...; pc/code pairs in order; first dec_valid 3 cycles after reset release.
- dec_ready=0 for 10 cycles -> at most DEPTH=2 requests issued, imem_req_valid drops to 0, code/pc stable; releasing dec_ready resumes at the next address with no loss.
- Redirect to 0x100 with 2 outstanding -> both stale responses dropped, state=DRAIN for 2 responses, first dec_valid shows pc=0x100.
- Redirect in the same cycle as a response arrives, with 1 outstanding -> drop_cnt=0, that word discarded, next delivered pc=redirect_pc.
- imem_req_ready toggling randomly with response latency 1–3 -> no duplicate or skipped PC, invariants hold.
- Assert rst_n mid-stream with 2 outstanding -> outputs return to reset values immediately, fetch restarts at RESET_PC.
